joy_serial_mp: RTL and testbench

//  Generalised user-port serial joystick reader: drives a daisy-chained 74165-style shift-register pad chain
//  via JOY_LOAD/JOY_CLK and samples JOY_DATA.

---
 rtl/joy_serial_mp_pkg.sv | 36 +++
 rtl/joy_frame_filter.sv | 61 ++++++
 rtl/joy_serial_mp.sv | 191 +++++++++++++++++++
 tb/tb_joy_serial_mp.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/joy_serial_mp_pkg.sv
// Shared types and elaboration helpers for the serial joystick reader.
// Holds the scan FSM state type, counter-width sizing and parameter range checks.
package joy_serial_mp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SH_LO = 3'd2,
      ST_SH_HI = 3'd3,
      ST_DONE  = 3'd4
   } joy_state_e;

   // Bits needed to hold any value in 0..max_val (at least one bit).
   function automatic int cnt_w(input int max_val);
      int w;
      if (max_val < 1) begin
         w = 1;
      end else begin
         w = $clog2(max_val + 1);
      end
      return w;
   endfunction

   function automatic bit params_ok(input int players, input int bits, input int clk_div,
                                    input int gap, input int filter);
      bit ok;
      ok = 1'b1;
      if (players < 1 || players > 4) ok = 1'b0;
      if (bits < 1 || bits > 16)       ok = 1'b0;
      if (clk_div < 2)                 ok = 1'b0;
      if (gap < 1)                     ok = 1'b0;
      if (filter < 1 || filter > 15)   ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/joy_frame_filter.sv
// Glitch filter for captured pad frames: the output only follows a frame once
// FILTER consecutive identical frames have been seen.
module joy_frame_filter
   import joy_serial_mp_pkg::*;
#(
   parameter int W      = 24,
   parameter int FILTER = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid_i,
   input  logic [W-1:0] frame_i,
   output logic [W-1:0] frame_o
);

   localparam int CW = cnt_w(FILTER);

   logic [W-1:0]  prev_q, prev_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  out_q, out_d;

   // Run-length of identical frames, saturating at FILTER; output follows once it is reached.
   always_comb begin
      prev_d = prev_q;
      cnt_d  = cnt_q;
      out_d  = out_q;
      if (valid_i) begin
         prev_d = frame_i;
         if (frame_i != prev_q) begin
            cnt_d = CW'(1);
         end else if (cnt_q != CW'(FILTER)) begin
            cnt_d = cnt_q + CW'(1);
         end else begin
            cnt_d = cnt_q;
         end
         if (cnt_d == CW'(FILTER)) begin
            out_d = frame_i;
         end else begin
            out_d = out_q;
         end
      end else begin
         prev_d = prev_q;
      end
   end

   // Filter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= '0;
         cnt_q  <= '0;
         out_q  <= '0;
      end else begin
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
         out_q  <= out_d;
      end
   end

   assign frame_o = out_q;

endmodule

// File: rtl/joy_serial_mp.sv
// Serial joystick reader for a daisy-chained 74165-style pad chain: generates
// JOY_LOAD/JOY_CLK, samples JOY_DATA and presents a filtered, active-high pad image.
module joy_serial_mp
   import joy_serial_mp_pkg::*;
#(
   parameter int PLAYERS    = 2,
   parameter int BITS       = 12,
   parameter int CLK_DIV    = 24,
   parameter int GAP        = 16,
   parameter int FILTER     = 2,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    JOY_DATA,
   output logic                    JOY_CLK,
   output logic                    JOY_LOAD,
   output logic [PLAYERS*BITS-1:0] joystick,
   output logic                    frame_strobe
);

   localparam int NB = PLAYERS * BITS;
   localparam int KW = cnt_w(NB);
   localparam int DW = $clog2(CLK_DIV);
   localparam int GW = cnt_w(GAP - 1);

   if (!params_ok(PLAYERS, BITS, CLK_DIV, GAP, FILTER)) begin : g_param_check
      $error("joy_serial_mp: parameter out of range");
   end

   logic [1:0]    rst_sync_q;
   logic          rst_int_n;
   logic [1:0]    data_sync_q;
   logic          sample_s;
   logic          tick_s;
   logic [DW-1:0] div_q, div_d;
   joy_state_e    state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [NB-1:0] shift_q, shift_d;
   logic          joy_clk_q, joy_load_q, strobe_q;

   // Reset synchroniser: assertion is immediate, release is aligned to clk.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[1];

   // JOY_DATA synchroniser.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         data_sync_q <= {2{ACTIVE_LOW}};
      end else begin
         data_sync_q <= {data_sync_q[0], JOY_DATA};
      end
   end

   // Pressed buttons are stored as 1 regardless of the chain polarity.
   assign sample_s = data_sync_q[1] ^ ACTIVE_LOW;
   // The divider stalls in DONE, which makes that state cost exactly one clk.
   assign tick_s   = enable && (state_q != ST_DONE) && (div_q == DW'(CLK_DIV - 1));

   // Tick divider.
   always_comb begin
      div_d = div_q;
      if (!enable) begin
         div_d = '0;
      end else if (state_q == ST_DONE) begin
         div_d = div_q;
      end else if (tick_s) begin
         div_d = '0;
      end else begin
         div_d = div_q + DW'(1);
      end
   end

   // Scan FSM next state, bit counter, gap counter and shift capture.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      gap_d   = gap_q;
      shift_d = shift_q;
      if (!enable) begin
         state_d = ST_IDLE;
         k_d     = '0;
         gap_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tick_s) begin
                  if (gap_q == GW'(GAP - 1)) begin
                     gap_d   = '0;
                     state_d = ST_LOAD;
                  end else begin
                     gap_d   = gap_q + GW'(1);
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (tick_s) begin
                  state_d = ST_SH_LO;
               end else begin
                  state_d = ST_LOAD;
               end
            end
            ST_SH_LO: begin
               if (tick_s) begin
                  for (int i = 0; i < NB; i++) begin
                     if (k_q == KW'(i)) begin
                        shift_d[i] = sample_s;
                     end else begin
                        shift_d[i] = shift_q[i];
                     end
                  end
                  state_d = ST_SH_HI;
               end else begin
                  state_d = ST_SH_LO;
               end
            end
            ST_SH_HI: begin
               if (tick_s) begin
                  k_d = k_q + KW'(1);
                  if (k_q == KW'(NB - 1)) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_SH_LO;
                  end
               end else begin
                  state_d = ST_SH_HI;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               k_d     = '0;
            end
            default: begin
               state_d = ST_IDLE;
               k_d     = '0;
               gap_d   = '0;
            end
         endcase
      end
   end

   // State, counters and outputs; outputs are decoded from next state so they are registered.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         div_q      <= '0;
         state_q    <= ST_IDLE;
         k_q        <= '0;
         gap_q      <= '0;
         shift_q    <= '0;
         joy_clk_q  <= 1'b0;
         joy_load_q <= 1'b1;
         strobe_q   <= 1'b0;
      end else begin
         div_q      <= div_d;
         state_q    <= state_d;
         k_q        <= k_d;
         gap_q      <= gap_d;
         shift_q    <= shift_d;
         joy_clk_q  <= (state_d == ST_SH_HI);
         joy_load_q <= (state_d != ST_LOAD);
         strobe_q   <= (state_d == ST_DONE);
      end
   end

   joy_frame_filter #(
      .W      (NB),
      .FILTER (FILTER)
   ) u_filter (
      .clk     (clk),
      .rst_n   (rst_int_n),
      .valid_i (state_q == ST_DONE),
      .frame_i (shift_q),
      .frame_o (joystick)
   );

   assign JOY_CLK      = joy_clk_q;
   assign JOY_LOAD     = joy_load_q;
   assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_joy_serial_mp.sv
// Bench for joy_serial_mp: models a 24-bit 74165 pad chain and a frame-history
// filter model, checks joystick every cycle plus directed timing/value checks.
module tb_joy_serial_mp;

   localparam int PLAYERS = 2;
   localparam int BITS    = 12;
   localparam int NB      = PLAYERS * BITS;
   localparam int CLK_DIV = 4;
   localparam int GAP     = 8;
   localparam int FILTER  = 2;

   logic          clk     = 1'b0;
   logic          reset_n = 1'b1;
   logic          enable  = 1'b0;
   logic          JOY_DATA;
   logic          JOY_CLK;
   logic          JOY_LOAD;
   logic [NB-1:0] joystick;
   logic          frame_strobe;

   logic [NB-1:0] pads_n    = '1;   // pad lines as seen by the chain, 0 = pressed
   logic [NB-1:0] chain     = '1;
   logic [NB-1:0] cap_frame = '0;   // active-high image latched at the last load
   logic [NB-1:0] exp_joy   = '0;
   logic [NB-1:0] hist[$];

   int cyc            = 0;
   int rise_total     = 0;
   int rise_at_strobe = 0;
   int rises_in_frame = 0;
   int load_fall_cyc  = 0;
   int last_load_w    = 0;
   int n_strobes      = 0;
   int last_strobe_cyc = 0;
   int strobe_period  = 0;
   int n_vec          = 0;
   int n_bad          = 0;

   joy_serial_mp #(
      .PLAYERS    (PLAYERS),
      .BITS       (BITS),
      .CLK_DIV    (CLK_DIV),
      .GAP        (GAP),
      .FILTER     (FILTER),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .JOY_DATA     (JOY_DATA),
      .JOY_CLK      (JOY_CLK),
      .JOY_LOAD     (JOY_LOAD),
      .joystick     (joystick),
      .frame_strobe (frame_strobe)
   );

   always #5 clk = ~clk;

   always @(negedge clk) cyc <= cyc + 1;

   // 74165 chain: parallel load while JOY_LOAD low, shift toward JOY_DATA on JOY_CLK rise.
   always @(negedge JOY_LOAD or posedge JOY_CLK) begin
      if (!JOY_LOAD) begin
         chain         <= pads_n;
         cap_frame     <= ~pads_n;
         load_fall_cyc <= cyc;
      end else begin
         chain      <= {1'b1, chain[NB-1:1]};
         rise_total <= rise_total + 1;
      end
   end

   assign JOY_DATA = chain[0];

   always @(posedge JOY_LOAD) last_load_w <= cyc - load_fall_cyc;

   // The last FILTER complete frames all equal means the pad image is accepted.
   function automatic logic settled();
      logic ok;
      ok = (hist.size() == FILTER);
      for (int i = 0; i < hist.size(); i++) begin
         if (hist[i] !== hist[0]) ok = 1'b0;
      end
      return ok;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist.delete();
         exp_joy <= '0;
      end else if (frame_strobe === 1'b1) begin
         hist.push_back(cap_frame);
         if (hist.size() > FILTER) void'(hist.pop_front());
         if (settled()) exp_joy <= cap_frame;
         n_strobes       <= n_strobes + 1;
         strobe_period   <= cyc - last_strobe_cyc;
         last_strobe_cyc <= cyc;
         rises_in_frame  <= rise_total - rise_at_strobe;
         rise_at_strobe  <= rise_total;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: every cycle the joystick must track the model; during reset the pins must idle.
   task automatic step();
      @(negedge clk);
      n_vec++;
      if (joystick !== exp_joy) begin
         n_bad++;
         if (n_bad <= 20) $display("FAIL joystick_track: got %h, expected %h (t=%0t)", joystick, exp_joy, $time);
      end
      if (!reset_n) begin
         n_vec++;
         if (JOY_CLK !== 1'b0 || JOY_LOAD !== 1'b1 || frame_strobe !== 1'b0) begin
            n_bad++;
            if (n_bad <= 20) $display("FAIL reset_pins: got clk=%b load=%b strobe=%b, expected 0/1/0", JOY_CLK, JOY_LOAD, frame_strobe);
         end
      end
   endtask

   task automatic wait_strobe(input string name);
      int start;
      int b;
      start = n_strobes;
      b = 0;
      while (n_strobes == start && b < 600) begin
         step();
         b++;
      end
      if (n_strobes == start) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: got no frame_strobe, expected one within 600 clk", name);
      end
   endtask

   task automatic wait_rises(input int n, input string name);
      int start;
      int b;
      start = rise_total;
      b = 0;
      while ((rise_total - start) < n && b < 600) begin
         step();
         b++;
      end
      if ((rise_total - start) < n) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: got %0d JOY_CLK rises, expected %0d", name, rise_total - start, n);
      end
   endtask

   initial begin
      int n;
      int saved;
      enable = 1'b1;
      #2 reset_n = 1'b0;
      repeat (12) step();
      chk("reset_joystick", {8'h0, joystick}, 32'h0);
      chk("reset_joy_clk", {31'h0, JOY_CLK}, 32'h0);
      chk("reset_joy_load", {31'h0, JOY_LOAD}, 32'h1);
      chk("reset_no_edges", 32'(rise_total), 32'd0);
      reset_n = 1'b1;

      // Idle pads: frame timing
      wait_strobe("frame1");
      wait_strobe("frame2");
      chk("strobe_period", 32'(strobe_period), 32'd229);
      chk("rises_per_frame", 32'(rises_in_frame), 32'd24);
      chk("load_low_width", 32'(last_load_w), 32'd4);
      chk("idle_joystick", {8'h0, joystick}, 32'h0);

      // Single-frame glitch on bit5 must be rejected
      pads_n = ~24'h000020;
      wait_strobe("glitch_frame");
      pads_n = '1;
      chk("glitch_rejected", {8'h0, joystick}, 32'h0);
      wait_strobe("after_glitch1");
      chk("after_glitch1", {8'h0, joystick}, 32'h0);
      wait_strobe("after_glitch2");
      chk("after_glitch2", {8'h0, joystick}, 32'h0);

      // P1 bit0 and P2 bit4 pressed
      pads_n = ~24'h010001;
      wait_strobe("press1");
      chk("press_after_1st", {8'h0, joystick}, 32'h0);
      chk("model_after_1st", {8'h0, exp_joy}, 32'h0);
      wait_strobe("press2");
      chk("press_after_2nd", {8'h0, joystick}, 32'h010001);
      chk("model_after_2nd", {8'h0, exp_joy}, 32'h010001);

      // Drop enable at the 10th JOY_CLK rise
      wait_rises(10, "rises_before_disable");
      chk("clk_high_at_10th", {31'h0, JOY_CLK}, 32'h1);
      enable = 1'b0;
      step();
      chk("disable_joy_clk", {31'h0, JOY_CLK}, 32'h0);
      chk("disable_joy_load", {31'h0, JOY_LOAD}, 32'h1);
      chk("disable_joystick_held", {8'h0, joystick}, 32'h010001);
      saved = rise_total;
      repeat (20) step();
      chk("disabled_no_edges", 32'(rise_total - saved), 32'd0);
      enable = 1'b1;
      n = 0;
      while (JOY_LOAD === 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk("reenable_load_delay", 32'(n), 32'd32);
      wait_strobe("after_reenable");
      chk("after_reenable", {8'h0, joystick}, 32'h010001);

      // Reset pulse during SH_HI
      wait_rises(5, "rises_before_reset");
      chk("clk_high_before_reset", {31'h0, JOY_CLK}, 32'h1);
      reset_n = 1'b0;
      #1;
      chk("async_reset_joy_clk", {31'h0, JOY_CLK}, 32'h0);
      chk("async_reset_joy_load", {31'h0, JOY_LOAD}, 32'h1);
      chk("async_reset_joystick", {8'h0, joystick}, 32'h0);
      repeat (4) step();
      reset_n = 1'b1;
      wait_strobe("post_reset1");
      chk("post_reset_1st", {8'h0, joystick}, 32'h0);
      wait_strobe("post_reset2");
      chk("post_reset_2nd", {8'h0, joystick}, 32'h010001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
